// File: rtl/pipeline_distribute_pkg.sv
// Shared constants for the 1-to-N valid/ready stream fork.
// Holds the default output count used by pipeline_distribute.
package pipeline_distribute_pkg;

    localparam int unsigned PD_DEFAULT_N = 2;

endpackage

// File: rtl/pipeline_distribute_bind.sv
// Protocol checker for pipeline_distribute, bound into every instance.
// Ports mirror the DUT handshakes plus internal full/all_done.
module pipeline_distribute_sva #(
    parameter int N = 2
) (
    input logic clk,
    input logic rst_n,
    input logic i_valid,
    input logic i_ready,
    input logic o_valid [N],
    input logic o_ready [N],
    input logic full,
    input logic all_done
);

    logic [N-1:0] fired_q;
    logic [N-1:0] fired_d;
    logic [N-1:0] xfer;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            xfer[i] = o_valid[i] & o_ready[i];
        end
        fired_d = fired_q | xfer;
        if ((i_valid && i_ready) || (full && all_done)) begin
            fired_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fired_q <= '0;
        end else begin
            fired_q <= fired_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_once
        a_once: assert property (@(posedge clk) disable iff (!rst_n)
            !(fired_q[g] && xfer[g]));
    end

    a_ready: assert property (@(posedge clk) disable iff (!rst_n)
        i_ready |-> (!full || all_done));

endmodule

bind pipeline_distribute pipeline_distribute_sva #(.N(N)) u_sva (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .full     (full_q),
    .all_done (all_done)
);

// File: rtl/pipeline_distribute.sv
// 1-to-N valid/ready fork: each input token is held in a one-entry
// stage and delivered exactly once to every output before release.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_valid / i_ready   upstream handshake
//   o_valid / o_ready   per-output handshakes, unpacked [N]
// Macro PIPELINE_DISTRIBUTE_EAGER_EN selects the eager fork with a
// per-output sent register; otherwise a lazy all-at-once fork.
// Payload is not carried; load it with i_valid & i_ready.
module pipeline_distribute
    import pipeline_distribute_pkg::*;
#(
    parameter int N = PD_DEFAULT_N
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    output logic i_ready,
    output logic o_valid [N],
    input  logic o_ready [N]
);

    logic         full_q;
    logic         full_d;
    logic [N-1:0] done;
    logic         all_done;
    logic         accept;
    logic         release_tok;

    assign all_done    = &done;
    assign i_ready     = ~full_q | all_done;
    assign accept      = i_valid & i_ready;
    assign release_tok = full_q & all_done;

`ifdef PIPELINE_DISTRIBUTE_EAGER_EN
    logic [N-1:0] sent_q;
    logic [N-1:0] sent_d;

    // o_valid comes from flops only; fired outputs stay quiet.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            o_valid[i] = full_q & ~sent_q[i];
            done[i]    = sent_q[i] | (o_valid[i] & o_ready[i]);
        end
    end

    always_comb begin
        sent_d = sent_q;
        if (accept || release_tok) begin
            sent_d = '0;
        end else if (full_q) begin
            sent_d = done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end
`else
    logic others;

    // Each output only sees valid when every other output is ready,
    // so all outputs transfer in the same cycle or not at all.
    always_comb begin
        others = 1'b1;
        for (int i = 0; i < N; i++) begin
            others = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (j != i) begin
                    others = others & o_ready[j];
                end
            end
            o_valid[i] = full_q & others;
            done[i]    = o_valid[i] & o_ready[i];
        end
    end
`endif

    // Accept wins over release so back-to-back tokens keep full set.
    always_comb begin
        full_d = full_q;
        if (accept) begin
            full_d = 1'b1;
        end else if (release_tok) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

endmodule

// File: tb/tb_pipeline_distribute.sv
// Directed bench for pipeline_distribute with N = 1, 2 and 3.
// Expectations follow the eager or lazy build of the DUT.
module tb_pipeline_distribute;

`ifdef PIPELINE_DISTRIBUTE_EAGER_EN
    localparam bit EAGER = 1'b1;
`else
    localparam bit EAGER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic iv1, ir1;
    logic ov1 [1];
    logic or1 [1];
    logic iv2, ir2;
    logic ov2 [2];
    logic or2 [2];
    logic iv3, ir3;
    logic ov3 [3];
    logic or3 [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_distribute #(.N(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv1),
        .i_ready(ir1), .o_valid(ov1), .o_ready(or1)
    );
    pipeline_distribute #(.N(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv2),
        .i_ready(ir2), .o_valid(ov2), .o_ready(or2)
    );
    pipeline_distribute #(.N(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv3),
        .i_ready(ir3), .o_valid(ov3), .o_ready(or3)
    );

    typedef struct {
        logic       iv;
        logic [1:0] rdy;
        logic       ir_e;
        logic [1:0] ov_e;
        logic       ir_l;
        logic [1:0] ov_l;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ov2_p();
        return {ov2[1], ov2[0]};
    endfunction

    function automatic logic [2:0] ov3_p();
        return {ov3[2], ov3[1], ov3[0]};
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc3;
        int cnt3 [3];
        int first3 [3];
        int last3 [3];
        int xfers;
        int n_in;
        int n_out;
        logic mf;

        tbl[0]  = '{1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 2'b00};
        tbl[1]  = '{1'b0, 2'b01, 1'b0, 2'b11, 1'b0, 2'b10};
        tbl[2]  = '{1'b0, 2'b01, 1'b0, 2'b10, 1'b0, 2'b10};
        tbl[3]  = '{1'b0, 2'b01, 1'b0, 2'b10, 1'b0, 2'b10};
        tbl[4]  = '{1'b1, 2'b11, 1'b1, 2'b10, 1'b1, 2'b11};
        tbl[5]  = '{1'b0, 2'b11, 1'b1, 2'b11, 1'b1, 2'b11};
        tbl[6]  = '{1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 2'b00};
        tbl[7]  = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 2'b00};
        tbl[8]  = '{1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 2'b00};
        tbl[9]  = '{1'b1, 2'b10, 1'b0, 2'b11, 1'b0, 2'b01};
        tbl[10] = '{1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 2'b10};

        // Reset held with i_valid high on every instance.
        iv1 = 1'b1; or1[0] = 1'b1;
        iv2 = 1'b1; or2[0] = 1'b1; or2[1] = 1'b1;
        iv3 = 1'b1;
        for (int i = 0; i < 3; i++) or3[i] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ov1", int'(ov1[0]), 0);
        chk("rst_ir1", int'(ir1), 1);
        chk("rst_ov2", int'(ov2_p()), 0);
        chk("rst_ir2", int'(ir2), 1);
        chk("rst_ov3", int'(ov3_p()), 0);
        chk("rst_ir3", int'(ir3), 1);

        iv1 = 1'b0;
        iv3 = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ov2", int'(ov2_p()), 0);
        next_cyc();
        chk("first_tok_ov2", int'(ov2_p()), 3);
        iv2 = 1'b0;
        next_cyc();

        for (int k = 0; k < 11; k++) begin
            iv2 = tbl[k].iv;
            or2[0] = tbl[k].rdy[0];
            or2[1] = tbl[k].rdy[1];
            #1;
            chk($sformatf("tbl%0d_ir", k), int'(ir2),
                int'(EAGER ? tbl[k].ir_e : tbl[k].ir_l));
            chk($sformatf("tbl%0d_ov", k), int'(ov2_p()),
                int'(EAGER ? tbl[k].ov_e : tbl[k].ov_l));
            next_cyc();
        end

        // Reset with output 1 still pending.
        iv2 = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        iv2 = 1'b1;
        or2[0] = 1'b1; or2[1] = 1'b1;
        next_cyc();
        iv2 = 1'b0;
        or2[1] = 1'b0;
        next_cyc();
        chk("mid_pend_ov2", int'(ov2_p()), 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov2", int'(ov2_p()), 0);
        chk("mid_rst_ir2", int'(ir2), 1);
        #1;
        rst_n = 1'b1;
        or2[1] = 1'b1;
        xfers = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            for (int i = 0; i < 2; i++)
                if (ov2[i] && or2[i]) xfers++;
            next_cyc();
        end
        chk("mid_rst_xfers", xfers, 0);

        // N = 3 full throughput.
        acc3 = 0;
        for (int i = 0; i < 3; i++) begin
            cnt3[i] = 0;
            first3[i] = -1;
            last3[i] = -1;
        end
        for (int c = 0; c < 12; c++) begin
            iv3 = (c < 10);
            #1;
            chk($sformatf("thr_ir3_c%0d", c), int'(ir3), 1);
            if (iv3 && ir3) acc3++;
            for (int i = 0; i < 3; i++) begin
                if (ov3[i] && or3[i]) begin
                    cnt3[i]++;
                    if (first3[i] < 0) first3[i] = c;
                    last3[i] = c;
                end
            end
            next_cyc();
        end
        chk("thr_acc3", acc3, 10);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("thr_cnt3_%0d", i), cnt3[i], 10);
            chk($sformatf("thr_first3_%0d", i), first3[i], 1);
            chk($sformatf("thr_last3_%0d", i), last3[i], 10);
        end

        // N = 1 random traffic against a one-entry register model.
        mf = 1'b0;
        n_in = 0;
        n_out = 0;
        for (int c = 0; c < 1000; c++) begin
            iv1 = 1'($urandom_range(0, 1));
            or1[0] = 1'($urandom_range(0, 1));
            #1;
            if (ov1[0] !== mf)
                chk($sformatf("n1_ov_c%0d", c), int'(ov1[0]), int'(mf));
            else
                checks++;
            if (ir1 !== (!mf || or1[0]))
                chk($sformatf("n1_ir_c%0d", c), int'(ir1),
                    int'(!mf || or1[0]));
            else
                checks++;
            if (iv1 && ir1) n_in++;
            if (ov1[0] && or1[0]) n_out++;
            if (iv1 && (!mf || or1[0])) mf = 1'b1;
            else if (mf && or1[0]) mf = 1'b0;
            next_cyc();
        end
        chk("n1_count", n_out, n_in - int'(mf));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
